// File: rtl/approx_mult_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | approx_mult_pkg                                                            |
// | Shared helpers for the approximate multiplier: low-bit masking and the     |
// | precise / carry-free partial-product combiners, width-generic via h.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package approx_mult_pkg;

    localparam int c_STATS_W = 32;
    // Working width for the generic helpers; WIDTH up to 32 keeps headroom.
    localparam int c_MAX_W   = 128;
    localparam logic [c_MAX_W-1:0] c_ONE = c_MAX_W'(1);

    function automatic logic [c_MAX_W-1:0] low_mask(input int n);
        return (c_ONE << n) - c_ONE;
    endfunction

    function automatic logic [c_MAX_W-1:0] approx_mask(input logic [c_MAX_W-1:0] p,
                                                       input int h);
        return p & ~low_mask(h / 2);
    endfunction

    function automatic logic [c_MAX_W-1:0] combine_precise(input logic [c_MAX_W-1:0] p_ll,
                                                           input logic [c_MAX_W-1:0] p_hl,
                                                           input logic [c_MAX_W-1:0] p_lh,
                                                           input logic [c_MAX_W-1:0] p_hh,
                                                           input int h);
        return (p_hh << (2 * h)) + ((p_hl + p_lh) << h) + p_ll;
    endfunction

    // Each h-bit output lane is the OR of the overlapping partial-product halves.
    function automatic logic [c_MAX_W-1:0] combine_approx(input logic [c_MAX_W-1:0] p_ll,
                                                          input logic [c_MAX_W-1:0] p_hl,
                                                          input logic [c_MAX_W-1:0] p_lh,
                                                          input logic [c_MAX_W-1:0] p_hh,
                                                          input int h);
        logic [c_MAX_W-1:0] m;
        m = low_mask(h);
        return (p_ll & m)
             | ((((p_ll >> h) | p_hl | p_lh) & m) << h)
             | ((((p_hl >> h) | (p_lh >> h) | p_hh) & m) << (2 * h))
             | (((p_hh >> h) & m) << (3 * h));
    endfunction

endpackage
`default_nettype wire

// File: rtl/approx_mult_half.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | approx_mult_half                                                           |
// | H x H unsigned multiplier; when approximate, the low H/2 product bits      |
// | are forced to zero.                                                        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module approx_mult_half
    import approx_mult_pkg::*;
#(
    parameter int H = 4
) (
    input  logic [H-1:0]   i_x,
    input  logic [H-1:0]   i_y,
    input  logic           i_approx_en,
    output logic [2*H-1:0] o_p
);

    logic [2*H-1:0]           w_exact;
    logic [c_MAX_W-1:0]       w_masked_full;
    logic [c_MAX_W-2*H-1:0]   w_unused_hi;

    assign w_exact       = {{H{1'b0}}, i_x} * {{H{1'b0}}, i_y};
    assign w_masked_full = approx_mask({{(c_MAX_W-2*H){1'b0}}, w_exact}, H);
    assign w_unused_hi   = w_masked_full[c_MAX_W-1:2*H];
    assign o_p           = i_approx_en ? w_masked_full[2*H-1:0] : w_exact;

endmodule
`default_nettype wire

// File: rtl/approx_mult_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | approx_mult_pipe                                                           |
// | Two-stage valid/ready approximate WIDTH x WIDTH multiplier with per-op     |
// | precise/approximate mode and tag sideband. APPROX_MULT_ERR_STATS_EN adds   |
// | run-time error statistics counters.                                        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module approx_mult_pipe
    import approx_mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_precise,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_y,
    output logic [TAG_W-1:0]     out_tag
`ifdef APPROX_MULT_ERR_STATS_EN
    ,
    input  logic                 stats_clr,
    output logic [c_STATS_W-1:0] stats_ops,
    output logic [c_STATS_W-1:0] stats_err_ops,
    output logic [c_STATS_W-1:0] stats_err_sum
`endif
);

    localparam int c_H = WIDTH / 2;

    logic                 w_adv;
    logic [2*c_H-1:0]     w_p_ll, w_p_hl, w_p_lh, w_p_hh;
    logic [c_MAX_W-1:0]   w_comb_full;
    logic [2*WIDTH-1:0]   w_y;
    logic [c_MAX_W-2*WIDTH-1:0] w_unused_comb;

    logic                 r_s1_valid;
    logic                 r_s1_precise;
    logic [TAG_W-1:0]     r_s1_tag;
    logic [2*c_H-1:0]     r_s1_p_ll, r_s1_p_hl, r_s1_p_lh, r_s1_p_hh;

    logic                 r_out_valid;
    logic [2*WIDTH-1:0]   r_out_y;
    logic [TAG_W-1:0]     r_out_tag;

    // Both stages move together, so a bubble in S1 cannot slip under a stalled S2.
    assign w_adv    = !r_out_valid || out_ready;
    assign in_ready = w_adv;

    approx_mult_half #(.H(c_H)) u_ll (
        .i_x(in_a[c_H-1:0]), .i_y(in_b[c_H-1:0]), .i_approx_en(1'b1), .o_p(w_p_ll)
    );
    approx_mult_half #(.H(c_H)) u_hl (
        .i_x(in_a[WIDTH-1:c_H]), .i_y(in_b[c_H-1:0]), .i_approx_en(!in_precise), .o_p(w_p_hl)
    );
    approx_mult_half #(.H(c_H)) u_lh (
        .i_x(in_a[c_H-1:0]), .i_y(in_b[WIDTH-1:c_H]), .i_approx_en(!in_precise), .o_p(w_p_lh)
    );
    approx_mult_half #(.H(c_H)) u_hh (
        .i_x(in_a[WIDTH-1:c_H]), .i_y(in_b[WIDTH-1:c_H]), .i_approx_en(1'b0), .o_p(w_p_hh)
    );

    always_comb begin
        w_comb_full = '0;
        if (r_s1_precise) begin
            w_comb_full = combine_precise({{(c_MAX_W-2*c_H){1'b0}}, r_s1_p_ll},
                                          {{(c_MAX_W-2*c_H){1'b0}}, r_s1_p_hl},
                                          {{(c_MAX_W-2*c_H){1'b0}}, r_s1_p_lh},
                                          {{(c_MAX_W-2*c_H){1'b0}}, r_s1_p_hh}, c_H);
        end else begin
            w_comb_full = combine_approx({{(c_MAX_W-2*c_H){1'b0}}, r_s1_p_ll},
                                         {{(c_MAX_W-2*c_H){1'b0}}, r_s1_p_hl},
                                         {{(c_MAX_W-2*c_H){1'b0}}, r_s1_p_lh},
                                         {{(c_MAX_W-2*c_H){1'b0}}, r_s1_p_hh}, c_H);
        end
    end

    assign w_y           = w_comb_full[2*WIDTH-1:0];
    assign w_unused_comb = w_comb_full[c_MAX_W-1:2*WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_precise <= 1'b0;
            r_s1_tag     <= '0;
            r_s1_p_ll    <= '0;
            r_s1_p_hl    <= '0;
            r_s1_p_lh    <= '0;
            r_s1_p_hh    <= '0;
            r_out_valid  <= 1'b0;
            r_out_y      <= '0;
            r_out_tag    <= '0;
        end else if (w_adv) begin
            r_s1_valid   <= in_valid;
            r_s1_precise <= in_precise;
            r_s1_tag     <= in_tag;
            r_s1_p_ll    <= w_p_ll;
            r_s1_p_hl    <= w_p_hl;
            r_s1_p_lh    <= w_p_lh;
            r_s1_p_hh    <= w_p_hh;
            r_out_valid  <= r_s1_valid;
            // Result registers only load real ops so bubbles leave the last value intact.
            if (r_s1_valid) begin
                r_out_y   <= w_y;
                r_out_tag <= r_s1_tag;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_y     = r_out_y;
    assign out_tag   = r_out_tag;

`ifdef APPROX_MULT_ERR_STATS_EN
    localparam int c_SUM_W = ((2*WIDTH > c_STATS_W) ? 2*WIDTH : c_STATS_W) + 1;
    localparam logic [c_SUM_W-1:0] c_SAT = {{(c_SUM_W-c_STATS_W){1'b0}}, {c_STATS_W{1'b1}}};

    logic [2*WIDTH-1:0]   r_s1_exact, r_s2_exact;
    logic [2*WIDTH-1:0]   w_diff;
    logic [c_SUM_W-1:0]   w_sum_ext;
    logic                 w_out_hs;
    logic [c_STATS_W-1:0] r_ops, r_err_ops, r_err_sum;

    assign w_out_hs  = r_out_valid && out_ready;
    assign w_diff    = (r_s2_exact >= r_out_y) ? (r_s2_exact - r_out_y) : (r_out_y - r_s2_exact);
    assign w_sum_ext = {{(c_SUM_W-c_STATS_W){1'b0}}, r_err_sum}
                     + {{(c_SUM_W-2*WIDTH){1'b0}}, w_diff};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_exact <= '0;
            r_s2_exact <= '0;
        end else if (w_adv) begin
            r_s1_exact <= {{WIDTH{1'b0}}, in_a} * {{WIDTH{1'b0}}, in_b};
            if (r_s1_valid) begin
                r_s2_exact <= r_s1_exact;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            r_ops     <= '0;
            r_err_ops <= '0;
            r_err_sum <= '0;
        end else if (w_out_hs) begin
            if (r_ops != {c_STATS_W{1'b1}}) begin
                r_ops <= r_ops + 1'b1;
            end
            if ((w_diff != '0) && (r_err_ops != {c_STATS_W{1'b1}})) begin
                r_err_ops <= r_err_ops + 1'b1;
            end
            r_err_sum <= (w_sum_ext > c_SAT) ? {c_STATS_W{1'b1}} : w_sum_ext[c_STATS_W-1:0];
        end
    end

    assign stats_ops     = r_ops;
    assign stats_err_ops = r_err_ops;
    assign stats_err_sum = r_err_sum;
`endif

endmodule
`default_nettype wire
